// File: rtl/bl_d1_row_ser8.sv
// Row serializer: buffers one 8-sample row from eight parallel streams and
// emits it as 8 sequential tokens on a single stream, element 0 first.

module bl_d1_row_ser8_lane #(
   parameter int W = 16
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         ld,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   always_ff @(posedge clock or posedge reset)
      if (reset)   q <= '0;
      else if (ld) q <= d;
endmodule

module bl_d1_row_ser8 #(
   parameter int W = 16
) (
   input  logic         clock,
   input  logic         reset,
   input  logic [W-1:0] i0_d, i1_d, i2_d, i3_d, i4_d, i5_d, i6_d, i7_d,
   input  logic         i0_v, i1_v, i2_v, i3_v, i4_v, i5_v, i6_v, i7_v,
   input  logic         i0_e, i1_e, i2_e, i3_e, i4_e, i5_e, i6_e, i7_e,
   output logic         i0_b, i1_b, i2_b, i3_b, i4_b, i5_b, i6_b, i7_b,
   output logic [W-1:0] o_d,
   output logic         o_v,
   output logic         o_e,
   input  logic         o_b,
   output logic         err
);
   localparam int LANES = 8;

   typedef enum logic [1:0] {LOAD, EMIT, EOS, DONE} state_t;

   state_t                      state, state_nx;
   logic [2:0]                  cnt, cnt_nx;
   logic                        err_nx;
   logic [LANES-1:0][W-1:0]     in_d, row_buf;
   logic [LANES-1:0]            in_v, in_e;
   logic                        allv, alle, anye, slot, fire, fire_eos, mixed, in_b;

   assign in_d = {i7_d, i6_d, i5_d, i4_d, i3_d, i2_d, i1_d, i0_d};
   assign in_v = {i7_v, i6_v, i5_v, i4_v, i3_v, i2_v, i1_v, i0_v};
   assign in_e = {i7_e, i6_e, i5_e, i4_e, i3_e, i2_e, i1_e, i0_e};

   assign allv     = &in_v;
   assign alle     = &in_e;
   assign anye     = |in_e;
   // A new row may enter while idle, or exactly as the last element leaves.
   assign slot     = (state == LOAD) || (state == EMIT && cnt == 3'd7 && !o_b);
   assign fire     = slot && allv && !anye;
   assign fire_eos = slot && allv && alle;
   assign mixed    = slot && allv && anye && !alle;

   // All-or-nothing consumption; held off while reset is asserted.
   assign in_b = reset || !(fire || fire_eos);
   assign {i7_b, i6_b, i5_b, i4_b, i3_b, i2_b, i1_b, i0_b} = {LANES{in_b}};

   assign o_v = (state == EMIT) || (state == EOS);
   assign o_e = (state == EOS);
   assign o_d = (state == EMIT) ? row_buf[cnt] : '0;

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      bl_d1_row_ser8_lane #(.W(W)) u_lane (
         .clock (clock),
         .reset (reset),
         .ld    (fire),
         .d     (in_d[k]),
         .q     (row_buf[k])
      );
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      err_nx   = err || mixed;
      case (state)
         LOAD: begin
            if (fire) begin
               cnt_nx   = 3'd0;
               state_nx = EMIT;
            end else if (fire_eos) begin
               state_nx = EOS;
            end
         end
         EMIT: begin
            if (!o_b) begin
               if (cnt != 3'd7) begin
                  cnt_nx = cnt + 3'd1;
               end else if (fire) begin
                  cnt_nx = 3'd0;
               end else if (fire_eos) begin
                  cnt_nx   = 3'd0;
                  state_nx = EOS;
               end else begin
                  cnt_nx   = 3'd0;
                  state_nx = LOAD;
               end
            end
         end
         EOS:     if (!o_b) state_nx = DONE;
         DONE:    state_nx = DONE;
         default: state_nx = LOAD;
      endcase
   end

   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         state <= LOAD;
         cnt   <= 3'd0;
         err   <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         err   <= err_nx;
      end
endmodule

// File: tb/tb_bl_d1_row_ser8.sv
// Bench for bl_d1_row_ser8: directed row/stall/EOS/error cases plus random
// traffic, all checked against a token-queue reference model.

module tb_bl_d1_row_ser8;
   localparam int W = 16;

   logic          clock = 1'b0;
   logic          reset;
   logic [W-1:0]  d [8];
   logic [7:0]    v, e, b;
   logic [W-1:0]  o_d;
   logic          o_v, o_e, o_b, err;

   int nchk = 0;
   int nerr = 0;

   typedef struct { logic [W-1:0] d; bit eos; } tok_t;
   tok_t q [$];
   bit   done_m, err_m, acc_m;

   always #5 clock = ~clock;

   bl_d1_row_ser8 #(.W(W)) dut (
      .clock(clock), .reset(reset),
      .i0_d(d[0]), .i1_d(d[1]), .i2_d(d[2]), .i3_d(d[3]),
      .i4_d(d[4]), .i5_d(d[5]), .i6_d(d[6]), .i7_d(d[7]),
      .i0_v(v[0]), .i1_v(v[1]), .i2_v(v[2]), .i3_v(v[3]),
      .i4_v(v[4]), .i5_v(v[5]), .i6_v(v[6]), .i7_v(v[7]),
      .i0_e(e[0]), .i1_e(e[1]), .i2_e(e[2]), .i3_e(e[3]),
      .i4_e(e[4]), .i5_e(e[5]), .i6_e(e[6]), .i7_e(e[7]),
      .i0_b(b[0]), .i1_b(b[1]), .i2_b(b[2]), .i3_b(b[3]),
      .i4_b(b[4]), .i5_b(b[5]), .i6_b(b[6]), .i7_b(b[7]),
      .o_d(o_d), .o_v(o_v), .o_e(o_e), .o_b(o_b), .err(err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      if (obs !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock cycle: check outputs against the model at the falling edge,
   // advance the model with this cycle's transfers, then wait past the edge.
   task automatic step();
      bit slot, allv, anye, alle, acce, mix, ev, ee;
      logic [W-1:0] ed;
      @(negedge clock);
      ev   = (q.size() != 0);
      ee   = ev && q[0].eos;
      ed   = (ev && !q[0].eos) ? q[0].d : '0;
      slot = !done_m && (q.size() == 0 || (q.size() == 1 && !o_b && !q[0].eos));
      allv = &v; anye = |e; alle = &e;
      acc_m = slot && allv && !anye;
      acce  = slot && allv && alle;
      mix   = slot && allv && anye && !alle;
      chk("in_b", b, {8{!(acc_m || acce)}});
      chk("o_v", o_v, ev);
      chk("o_e", o_e, ee);
      chk("o_d", o_d, ed);
      chk("err", err, err_m);
      if (ev && !o_b) begin
         if (q[0].eos) done_m = 1'b1;
         void'(q.pop_front());
      end
      if (acc_m) for (int k = 0; k < 8; k++) q.push_back('{d: d[k], eos: 1'b0});
      if (acce) q.push_back('{d: '0, eos: 1'b1});
      err_m = err_m || mix;
      @(posedge clock);
      #1;
   endtask

   task automatic set_row(input int base);
      for (int k = 0; k < 8; k++) d[k] = W'(base + k);
      v = 8'hff; e = 8'h00;
   endtask

   // Hold a row until it is taken; an expired budget counts as a failure.
   task automatic push_row(input int base);
      int n = 0;
      set_row(base);
      acc_m = 1'b0;
      while (!acc_m && n < 40) begin step(); n++; end
      chk("row_accept_timeout", acc_m, 1'b1);
   endtask

   task automatic idle(input int n);
      v = 8'h00; e = 8'h00;
      for (int i = 0; i < n; i++) step();
   endtask

   // Reset asserted between edges with all inputs valid: outputs must clear at once.
   task automatic do_reset();
      set_row(16'h55);
      #2 reset = 1'b1;
      #1;
      chk("rst_o_v", o_v, 1'b0);
      chk("rst_o_e", o_e, 1'b0);
      chk("rst_o_d", o_d, 0);
      chk("rst_err", err, 1'b0);
      chk("rst_in_b", b, 8'hff);
      q.delete(); done_m = 1'b0; err_m = 1'b0;
      @(posedge clock); #2;
      reset = 1'b0;
      v = 8'h00;
   endtask

   task automatic rand_cycle(input int bp_pct);
      for (int k = 0; k < 8; k++) d[k] = W'($urandom);
      v = ($urandom_range(0, 3) != 0) ? 8'hff : 8'($urandom);
      case ($urandom_range(0, 59))
         0:       e = 8'hff;
         1:       e = 8'h01 << $urandom_range(0, 7);
         default: e = 8'h00;
      endcase
      o_b = ($urandom_range(0, 99) < bp_pct);
      step();
   endtask

   initial begin
      reset = 1'b1; o_b = 1'b0; v = 8'h00; e = 8'h00;
      for (int k = 0; k < 8; k++) d[k] = '0;
      done_m = 1'b0; err_m = 1'b0; acc_m = 1'b0;
      #12;
      chk("por_o_v", o_v, 1'b0);
      chk("por_in_b", b, 8'hff);
      @(posedge clock); #2 reset = 1'b0;

      // Single row, then back-to-back rows with no output gap.
      push_row(0);
      idle(10);
      push_row(0);
      push_row(8);
      idle(12);

      // Output stall while element 3 is presented.
      push_row(32);
      v = 8'h00;
      while (q.size() != 0 && q[0].d != 16'd35) step();
      o_b = 1'b1;
      repeat (3) step();
      o_b = 1'b0;
      idle(8);

      // One lane missing holds everything off, without error.
      set_row(64); v[5] = 1'b0;
      repeat (3) step();
      push_row(64);
      idle(9);

      // End of stream after a row, then further rows are refused.
      push_row(80);
      v = 8'hff; e = 8'hff;
      repeat (12) step();
      set_row(96);
      repeat (4) step();
      do_reset();

      // Mixed end-of-stream flags raise the sticky error.
      set_row(112); e[2] = 1'b1;
      repeat (3) step();
      push_row(112);
      repeat (3) step();
      do_reset();
      push_row(128);
      idle(9);

      // Random traffic with a few mid-run resets.
      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < 300; i++) rand_cycle(r * 10);
         if (r % 2 == 1) do_reset();
      end
      o_b = 1'b0;
      idle(10);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule

// File: doc/bl_d1_row_ser8.md
Name: bl_d1_row_ser8

Overview:
- Downstream consumer of the 8-wide parallel pass-through stage in the JPEG decode chain.
- Takes one 8-sample row on eight parallel tokenised streams and buffers it.
- Emits the row as 8 sequential tokens on one output stream, index 0 first.
- Uses the standard stream protocol on every port: `_v` valid, `_e` end-of-stream, `_b` backpressure. A token moves when `_v && !_b`.

Parameters:
- W, 16, data width of every input sample and of the output sample.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- i0_d..i7_d  input  W each  row samples; index k is output position k.
- i0_v..i7_v  input  1 each  input token valid.
- i0_e..i7_e  input  1 each  input token is end-of-stream (data ignored).
- i0_b..i7_b  output  1 each  input backpressure; all eight always equal.
- o_d  output  W  serialized sample = buf[cnt].
- o_v  output  1  output token valid.
- o_e  output  1  output token is end-of-stream.
- o_b  input  1  output backpressure from consumer.
- err  output  1  sticky protocol error: mixed EOS across inputs.

Behaviour:
- State and storage:
  - States: LOAD, EMIT, EOS, DONE.
  - Registers: buf[0..7] (W each), cnt (3 bit), state, err.
- Reset (async, any time including mid-row):
  - state=LOAD, cnt=0, buf=0, err=0. Partially emitted row is discarded.
  - While reset is high: o_v=0, o_e=0, o_d=0, all i*_b=1.
- Outputs are decoded from registers only (no combinational path from inputs):
  - o_v = (state==EMIT) || (state==EOS).
  - o_e = (state==EOS).
  - o_d = buf[cnt] in EMIT, else 0.
- Definitions:
  - allv = AND of i0_v..i7_v.
  - alle = AND of i*_e.
  - anye = OR of i*_e.
  - slot = (state==LOAD) || (state==EMIT && cnt==7 && !o_b).
  - fire = slot && allv && !anye.
  - fire_eos = slot && allv && alle.
- Input backpressure, all-or-nothing:
  - i*_b = !(fire || fire_eos).
  - All eight inputs are consumed in the same cycle or none is.
- Transitions:
  - LOAD:
    - fire: buf[k] <= ik_d, cnt <= 0, go EMIT.
    - fire_eos: go EOS.
    - otherwise stay in LOAD.
  - EMIT with o_b=1: hold cnt, buf and o_d stable.
  - EMIT with o_b=0 and cnt<7: cnt <= cnt+1.
  - EMIT with o_b=0 and cnt==7:
    - fire: load the new row, cnt <= 0, stay in EMIT. No bubble; throughput is 8 cycles per row.
    - fire_eos: go EOS.
    - otherwise cnt <= 0, go LOAD.
  - EOS: hold o_v=1, o_e=1 until o_b=0, then go DONE.
  - DONE: o_v=0, i*_b=1 permanently until reset.
- Latency:
  - Row accepted at edge N; element 0 valid from cycle N+1.
  - Element k appears no earlier than N+1+k.
- Mixed EOS (slot && allv && anye && !alle):
  - No consumption; err <= 1 (sticky until reset).
  - State holds; the stall persists until inputs change.
- Partial validity (!allv): no consumption, no error.
- cnt wraps 7->0 only via the transitions above; no modular wrap anywhere else.

Test Plan:
- Row flow: reset, then present ik_d=k (k=0..7) all valid, o_b=0 -> i*_b low for exactly 1 cycle; o_d=0,1,...,7 on the next 8 consecutive cycles with o_v=1; then o_v=0.
- Back-to-back: rows 0..7 then 8..15 held valid -> 16 contiguous outputs 0..15 with no o_v gap; second row consumed in the same cycle o_d=7 transfers.
- Output stall: hold o_b=1 for 3 cycles while o_d=3 -> o_d stays 3, o_v stays 1, cnt frozen; values 4..7 then follow; no input consumed during the stall.
- Missing input: i5_v=0, others valid -> all i*_b=1, o_v=0, err=0; raising i5_v causes acceptance on the next edge.
- EOS: all ik_v=1, ik_e=1 after one row -> row emitted, then one token with o_v=1, o_e=1; then DONE; later valid rows see i*_b=1 and o_v=0.
- Mixed EOS and reset: i2_e=1, other i*_e=0, all valid -> err=1, nothing consumed; assert reset mid-row in a later run -> o_v=0, err=0, next row restarts at element 0.
